// File: rtl/music_pkg.sv
// Shared definitions for the buzzer music sequencer and the song ROM generator.
package music_pkg;

  // Default field widths of one song ROM word {tone, len}
  localparam int SONG_TONE_W = 6;
  localparam int SONG_LEN_W  = 4;

  // Bit positions of the fields inside a ROM word
  localparam int LEN_LSB  = 0;
  localparam int TONE_LSB = LEN_LSB + SONG_LEN_W;

  // Reserved tone codes: silence, and the end-of-song marker
  localparam logic [SONG_TONE_W-1:0] TONE_REST = '0;
  localparam logic [SONG_TONE_W-1:0] TONE_END  = '1;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4
  } seq_state_e;

  // Builds a ROM word from its fields, for song table generation
  function automatic logic [SONG_TONE_W+SONG_LEN_W-1:0] pack_note(
    input logic [SONG_TONE_W-1:0] tone,
    input logic [SONG_LEN_W-1:0]  len
  );
    return {tone, len};
  endfunction

endpackage

// File: rtl/beat_edge_det.sv
// Rising-edge detector for the beat counter's done flag. Preloading the
// history bit with 1 hides a flag that is already high when a note starts.
module beat_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic preload,
  output logic rise
);

  logic prev;

  // History register: forced high on preload, otherwise follows the input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else if (preload) begin
      prev <= 1'b1;
    end else begin
      prev <= din;
    end
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/music_sequencer.sv
// Song sequencer: fetches {tone, len} words from the song ROM, drives the tone
// divider and beat counter, and handles gaps, looping, stop and end of song.
module music_sequencer
  import music_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter int          TONE_W     = SONG_TONE_W,
  parameter int          LEN_W      = SONG_LEN_W,
  parameter logic [27:0] BEAT_UNIT  = 28'd3_125_000,
  parameter logic [27:0] GAP_CYCLES = 28'd250_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop_en,
  input  logic [ADDR_W-1:0]       song_base,
  output logic                    rom_rd,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [TONE_W+LEN_W-1:0] rom_data,
  output logic [TONE_W-1:0]       tone_code,
  output logic                    tone_en,
  output logic [27:0]             beat_param,
  output logic                    beat_clr,
  output logic                    beat_en,
  input  logic                    beat_done,
  output logic                    busy,
  output logic                    song_done
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [TONE_W-1:0] tone_q, tone_d;
  logic [LEN_W-1:0]  units_q, units_d;
  logic              clr_q, clr_d;
  logic              edge_preload;
  logic              beat_rise;
  logic [TONE_W-1:0] rom_tone;
  logic [LEN_W-1:0]  rom_len;

  assign rom_len  = rom_data[LEN_LSB +: LEN_W];
  assign rom_tone = rom_data[LEN_LSB + LEN_W +: TONE_W];

  beat_edge_det u_beat_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (beat_done),
    .preload (edge_preload),
    .rise    (beat_rise)
  );

  // State, address, note and beat-clear registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      tone_q  <= '0;
      units_q <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      tone_q  <= tone_d;
      units_q <= units_d;
      clr_q   <= clr_d;
    end
  end

  // Next-state logic; stop overrides everything and clears the beat counter
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    base_d       = base_q;
    tone_d       = tone_q;
    units_d      = units_q;
    clr_d        = 1'b0;
    edge_preload = 1'b0;
    song_done    = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      clr_d   = (state_q != ST_IDLE);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_d  = song_base;
            base_d  = song_base;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (&rom_tone) begin
            if (loop_en) begin
              addr_d  = base_q;
              state_d = ST_FETCH;
            end else begin
              song_done = 1'b1;
              state_d   = ST_IDLE;
            end
          end else begin
            tone_d       = rom_tone;
            units_d      = (rom_len == '0) ? LEN_W'(1) : rom_len;
            clr_d        = 1'b1;
            edge_preload = 1'b1;
            state_d      = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (beat_rise) begin
            clr_d   = 1'b1;
            units_d = units_q - LEN_W'(1);
            if (units_q == LEN_W'(1)) begin
              addr_d = addr_q + ADDR_W'(1);
              if (GAP_CYCLES == 28'd0) begin
                state_d = ST_FETCH;
              end else begin
                edge_preload = 1'b1;
                state_d      = ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (beat_rise) begin
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Beat counter terminal count follows the current timing phase
  always_comb begin
    beat_param = '0;
    if (state_q == ST_PLAY) begin
      beat_param = BEAT_UNIT;
    end else if (state_q == ST_GAP) begin
      beat_param = GAP_CYCLES;
    end
  end

  assign rom_rd    = (state_q == ST_FETCH);
  assign rom_addr  = addr_q;
  assign tone_code = tone_q;
  assign tone_en   = (state_q == ST_PLAY) && (tone_q != TONE_W'(TONE_REST));
  assign beat_en   = (state_q == ST_PLAY) || (state_q == ST_GAP);
  assign beat_clr  = clr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer with a song ROM, a beat counter
// model and a note-level reference model of playback timing.
module tb_music_sequencer;
  import music_pkg::*;

  localparam int          ADDR_W     = 8;
  localparam int          TONE_W     = 6;
  localparam int          LEN_W      = 4;
  localparam logic [27:0] BEAT_UNIT  = 28'd4;
  localparam logic [27:0] GAP_CYCLES = 28'd2;
  // A beat unit lasts the count plus one done cycle plus one clear cycle
  localparam int NOTE_CYC = int'(BEAT_UNIT) + 2;
  localparam int GAP_CYC  = int'(GAP_CYCLES) + 2;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic                    stop;
  logic                    loop_en;
  logic [ADDR_W-1:0]       song_base;
  logic                    rom_rd;
  logic [ADDR_W-1:0]       rom_addr;
  logic [TONE_W+LEN_W-1:0] rom_data;
  logic [TONE_W-1:0]       tone_code;
  logic                    tone_en;
  logic [27:0]             beat_param;
  logic                    beat_clr;
  logic                    beat_en;
  logic                    beat_done;
  logic                    busy;
  logic                    song_done;

  int checks = 0;
  int errors = 0;

  music_sequencer #(
    .ADDR_W     (ADDR_W),
    .TONE_W     (TONE_W),
    .LEN_W      (LEN_W),
    .BEAT_UNIT  (BEAT_UNIT),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .song_base  (song_base),
    .rom_rd     (rom_rd),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .tone_code  (tone_code),
    .tone_en    (tone_en),
    .beat_param (beat_param),
    .beat_clr   (beat_clr),
    .beat_en    (beat_en),
    .beat_done  (beat_done),
    .busy       (busy),
    .song_done  (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song ROM with one cycle of read latency
  logic [TONE_W+LEN_W-1:0] rom [256];
  always @(posedge clk) begin
    if (rom_rd) rom_data <= rom[rom_addr];
  end

  // Beat counter: done pulses for one cycle after beat_param enabled cycles
  logic [27:0] bcnt;
  logic        bdone_q;
  logic        ovr_en;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt    <= '0;
      bdone_q <= 1'b0;
    end else if (beat_clr) begin
      bcnt    <= '0;
      bdone_q <= 1'b0;
    end else if (beat_en) begin
      if (bcnt + 28'd1 == beat_param) begin
        bcnt    <= '0;
        bdone_q <= 1'b1;
      end else begin
        bcnt    <= bcnt + 28'd1;
        bdone_q <= 1'b0;
      end
    end else begin
      bdone_q <= 1'b0;
    end
  end
  assign beat_done = ovr_en | bdone_q;

  // Monitor: ROM reads, song_done pulses, busy cycles and tone_en runs
  int          busy_cnt   = 0;
  int          done_cnt   = 0;
  int          glitch_cnt = 0;
  logic [7:0]  rd_q [$];
  int          run_len_q [$];
  logic [5:0]  run_tone_q [$];
  logic        in_run     = 1'b0;
  int          run_len    = 0;
  logic [5:0]  run_tone   = '0;
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (song_done === 1'b1) done_cnt <= done_cnt + 1;
    if (rom_rd === 1'b1) rd_q.push_back(rom_addr);
    if (tone_en === 1'b1) begin
      if (!in_run) begin
        in_run   <= 1'b1;
        run_len  <= 1;
        run_tone <= tone_code;
      end else begin
        run_len <= run_len + 1;
        if (tone_code !== run_tone) glitch_cnt <= glitch_cnt + 1;
      end
    end else if (in_run) begin
      in_run <= 1'b0;
      run_len_q.push_back(run_len);
      run_tone_q.push_back(run_tone);
    end
  end

  // Song under test, one entry per note
  logic [5:0] note_tone [8];
  logic [3:0] note_len  [8];

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 600000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start pulse at the given base, then scramble song_base while busy
  task automatic applyStimulus(input logic [7:0] base);
    @(posedge clk); #1;
    song_base = base;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    song_base = 8'($urandom);
  endtask

  task automatic waitIdle(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (busy === 1'b0) seen = 1'b1;
    end
    #1;
    checkOutput({tag, "_idle_reached"}, 32'(seen), 32'd1);
  endtask

  task automatic waitTone(input logic lvl, input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (tone_en === lvl) seen = 1'b1;
    end
    checkOutput({tag, "_tone_reached"}, 32'(seen), 32'd1);
  endtask

  // Plays note_tone/note_len[0..k-1] then the end marker, compares to the model
  task automatic playSong(input logic [7:0] base, input int k, input string tag);
    int         rd0, rn0, dn0, bz0, gl0, exp_busy, exp_runs, ri, leff;
    logic [7:0] a;
    for (int i = 0; i < k; i++) begin
      a = base + 8'(i);
      rom[a] = pack_note(note_tone[i], note_len[i]);
    end
    a = base + 8'(k);
    rom[a] = pack_note(TONE_END, 4'($urandom));
    rd0 = rd_q.size();
    rn0 = run_len_q.size();
    dn0 = done_cnt;
    bz0 = busy_cnt;
    gl0 = glitch_cnt;
    applyStimulus(base);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    waitIdle(tag);
    checkOutput({tag, "_reads"}, 32'(rd_q.size() - rd0), 32'(k + 1));
    for (int i = 0; i <= k; i++) begin
      if (rd0 + i < rd_q.size())
        checkOutput($sformatf("%s_addr%0d", tag, i), 32'(rd_q[rd0 + i]), 32'(8'(base + 8'(i))));
    end
    exp_busy = 2;
    exp_runs = 0;
    ri       = rn0;
    for (int i = 0; i < k; i++) begin
      leff     = (note_len[i] == 4'd0) ? 1 : int'(note_len[i]);
      exp_busy += 2 + leff * NOTE_CYC + GAP_CYC;
      if (note_tone[i] != TONE_REST) begin
        exp_runs++;
        if (ri < run_len_q.size()) begin
          checkOutput($sformatf("%s_runlen%0d", tag, i), 32'(run_len_q[ri]), 32'(leff * NOTE_CYC));
          checkOutput($sformatf("%s_runtone%0d", tag, i), 32'(run_tone_q[ri]), 32'(note_tone[i]));
        end
        ri++;
      end
    end
    checkOutput({tag, "_runs"}, 32'(run_len_q.size() - rn0), 32'(exp_runs));
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt - bz0), 32'(exp_busy));
    checkOutput({tag, "_song_done"}, 32'(done_cnt - dn0), 32'd1);
    checkOutput({tag, "_tone_stable"}, 32'(glitch_cnt - gl0), 32'd0);
  endtask

  // Holds beat_done high for three cycles right after a note starts
  task automatic heldBeat(input logic [3:0] len, input string tag);
    int rn0, leff;
    rom[0] = pack_note(6'd4, len);
    rom[1] = pack_note(TONE_END, 4'd0);
    rn0  = run_len_q.size();
    leff = (len == 4'd0) ? 1 : int'(len);
    applyStimulus(8'd0);
    waitTone(1'b1, tag);
    @(posedge clk); #1;
    ovr_en = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    ovr_en = 1'b0;
    waitIdle(tag);
    checkOutput({tag, "_runs"}, 32'(run_len_q.size() - rn0), 32'd1);
    if (run_len_q.size() > rn0)
      checkOutput({tag, "_runlen"}, 32'(run_len_q[rn0]), 32'(2 + (leff - 1) * NOTE_CYC));
  endtask

  initial begin
    int rd0, dn0, k;
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    loop_en   = 1'b0;
    song_base = '0;
    ovr_en    = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = pack_note(TONE_END, 4'd0);

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",       32'(busy),       32'd0);
    checkOutput("rst_rom_rd",     32'(rom_rd),     32'd0);
    checkOutput("rst_rom_addr",   32'(rom_addr),   32'd0);
    checkOutput("rst_tone_code",  32'(tone_code),  32'd0);
    checkOutput("rst_tone_en",    32'(tone_en),    32'd0);
    checkOutput("rst_beat_param", 32'(beat_param), 32'd0);
    checkOutput("rst_beat_clr",   32'(beat_clr),   32'd0);
    checkOutput("rst_beat_en",    32'(beat_en),    32'd0);
    checkOutput("rst_song_done",  32'(song_done),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] single note then end");
    note_tone[0] = 6'd5; note_len[0] = 4'd2;
    playSong(8'd0, 1, "note52");

    $display("[TB] rest note");
    note_tone[0] = 6'd0; note_len[0] = 4'd1;
    playSong(8'd0, 1, "rest");

    $display("[TB] address wrap");
    note_tone[0] = 6'd9; note_len[0] = 4'd1;
    playSong(8'd255, 1, "wrap");

    $display("[TB] loop mode");
    rom[0]  = pack_note(6'd3, 4'd1);
    rom[1]  = pack_note(TONE_END, 4'd0);
    loop_en = 1'b1;
    rd0 = rd_q.size();
    dn0 = done_cnt;
    applyStimulus(8'd0);
    repeat (40) @(negedge clk);
    #1;
    checkOutput("loop_reads_ge4", 32'(rd_q.size() - rd0 >= 4), 32'd1);
    for (int i = rd0; i < rd_q.size(); i++)
      checkOutput($sformatf("loop_addr%0d", i - rd0), 32'(rd_q[i]), 32'((i - rd0) % 2));
    checkOutput("loop_no_done", 32'(done_cnt - dn0), 32'd0);
    @(posedge clk); #1; stop = 1'b1; loop_en = 1'b0;
    @(posedge clk); #1; stop = 1'b0;
    @(negedge clk);
    checkOutput("loop_stopped", 32'(busy), 32'd0);

    $display("[TB] stop mid-note");
    rom[0] = pack_note(6'd7, 4'd15);
    rom[1] = pack_note(TONE_END, 4'd0);
    dn0 = done_cnt;
    applyStimulus(8'd0);
    waitTone(1'b1, "stop");
    repeat (5) @(negedge clk);
    @(posedge clk); #1; stop = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("stop_busy",     32'(busy),     32'd0);
    checkOutput("stop_tone_en",  32'(tone_en),  32'd0);
    checkOutput("stop_beat_en",  32'(beat_en),  32'd0);
    checkOutput("stop_beat_clr", 32'(beat_clr), 32'd1);
    @(posedge clk); #1; start = 1'b1;
    @(negedge clk);
    checkOutput("stop_clr_once", 32'(beat_clr), 32'd0);
    @(negedge clk);
    checkOutput("startstop_idle", 32'(busy), 32'd0);
    @(posedge clk); #1; start = 1'b0; stop = 1'b0;
    @(negedge clk); #1;
    checkOutput("stop_no_done", 32'(done_cnt - dn0), 32'd0);

    $display("[TB] held beat_done");
    heldBeat(4'd0, "held_len0");
    heldBeat(4'd2, "held_len2");

    $display("[TB] async reset in gap");
    rom[0] = pack_note(6'd6, 4'd1);
    rom[1] = pack_note(TONE_END, 4'd0);
    applyStimulus(8'd0);
    waitTone(1'b1, "arst_on");
    waitTone(1'b0, "arst_off");
    checkOutput("arst_in_gap", 32'(beat_en), 32'd1);
    #2; rst_n = 1'b0;
    #1;
    checkOutput("arst_busy",       32'(busy),       32'd0);
    checkOutput("arst_beat_en",    32'(beat_en),    32'd0);
    checkOutput("arst_beat_clr",   32'(beat_clr),   32'd0);
    checkOutput("arst_rom_addr",   32'(rom_addr),   32'd0);
    checkOutput("arst_tone_code",  32'(tone_code),  32'd0);
    checkOutput("arst_beat_param", 32'(beat_param), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    $display("[TB] random songs");
    for (int s = 0; s < 8; s++) begin
      k = int'($urandom_range(1, 4));
      for (int i = 0; i < k; i++) begin
        note_tone[i] = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 62));
        note_len[i]  = 4'($urandom_range(0, 3));
      end
      playSong(8'($urandom_range(0, 255)), k, $sformatf("rand%0d", s));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
